mult_result_queue: RTL and testbench

- Downstream companion of the pipelined multiplier.
- Accepts issue requests from the multiply reservation-station port and generates the multiplier's start pulse.
- Carries each operation's destination tag alongside the fixed-latency pipeline and captures the cropped product when the multiplier signals done.
- Buffers results in a small FIFO until the CDB arbiter grants a broadcast slot; credit-based admission means results are never dropped.

---
 rtl/mult_result_queue_pkg.sv | 17 +
 rtl/mult_result_queue_if.sv | 34 +++
 rtl/mult_result_queue_fifo.sv | 68 ++++++
 rtl/mult_result_queue.sv | 101 ++++++++++
 tb/tb_mult_result_queue.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mult_result_queue_pkg.sv
// Shared definitions for the multiply result queue and its neighbours.
//   MULT_STAGES : latency of the pipelined multiplier, start to done
//   XLEN        : datapath width of the cropped product
//   MRQ_TAG_W   : destination physical-register tag width
//   mult_result_t : {tag, value} record handed to the CDB arbiter
package mult_result_queue_pkg;

  localparam int MULT_STAGES = 4;
  localparam int XLEN        = 32;
  localparam int MRQ_TAG_W   = 6;

  typedef struct packed {
    logic [MRQ_TAG_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } mult_result_t;

endpackage

// File: rtl/mult_result_queue_if.sv
// Bundle of the handshakes between the result queue and its neighbours:
// the multiply reservation station (issue_*), the pipelined multiplier
// (mult_*) and the CDB arbiter (cdb_*).
//   slave  : view used by the result queue itself
//   master : view used by the surrounding logic (or a testbench)
interface mult_result_queue_if
  import mult_result_queue_pkg::*;
#(
  parameter int TAG_W = MRQ_TAG_W,
  parameter int W     = XLEN
);

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             mult_start;
  logic             mult_done;
  logic [W-1:0]     mult_product;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [W-1:0]     cdb_value;
  logic             cdb_grant;

  modport slave (
    input  issue_valid, issue_tag, mult_done, mult_product, cdb_grant,
    output issue_ready, mult_start, cdb_valid, cdb_tag, cdb_value
  );

  modport master (
    output issue_valid, issue_tag, mult_done, mult_product, cdb_grant,
    input  issue_ready, mult_start, cdb_valid, cdb_tag, cdb_value
  );

endinterface

// File: rtl/mult_result_queue_fifo.sv
// Small circular result buffer with show-ahead output.
//   clock, reset : system clock, synchronous active-high reset
//   i_flush      : empties the buffer, overriding push and pop
//   i_push       : write i_pushData at the tail
//   i_pop        : retire the head entry (ignored while empty)
//   o_headData   : current head entry, valid whenever o_empty is low
//   o_empty/o_full : occupancy flags
module mult_result_fifo
  import mult_result_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  mult_result_t i_pushData,
  input  logic         i_pop,
  output mult_result_t o_headData,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mult_result_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop      = i_pop & ~o_empty;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_headData = r_mem[r_head];

  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= nextPtr(r_tail);
      if (w_pop)  r_head <= nextPtr(r_head);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clock) begin
    if (i_push && !reset && !i_flush) r_mem[r_tail] <= i_pushData;
  end

  // Admission credits make a push into a full, non-draining buffer impossible.
  assert property (@(posedge clock) disable iff (reset || i_flush)
                   !(i_push && o_full && !i_pop));

endmodule

// File: rtl/mult_result_queue.sv
// Downstream companion of the pipelined multiplier. Accepts multiply issues,
// fires the multiplier start pulse, carries each destination tag alongside the
// fixed-latency pipe, captures the product on completion and buffers results
// until the CDB arbiter grants a broadcast.
//   clock, reset : system clock, synchronous active-high reset
//   squash       : flush of every in-flight and buffered op
//   bus          : issue / multiplier / CDB handshakes (slave view)
module mult_result_queue
  import mult_result_queue_pkg::*;
#(
  parameter int TAG_W = MRQ_TAG_W,
  parameter int DEPTH = 4,
  parameter int LAT   = MULT_STAGES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  mult_result_queue_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Credits: in-flight ops plus buffered results, capped at DEPTH so every
  // op that enters the multiplier is guaranteed a buffer slot.
  logic [CNT_W-1:0] r_count;
  logic [LAT-1:0]   r_pipeValid;
  logic [TAG_W-1:0] r_pipeTag [LAT];

  logic         w_fire;
  logic         w_pop;
  logic         w_empty;
  logic         w_full;
  mult_result_t w_pushData;
  mult_result_t w_head;

  // Reset behaves like squash, so neither may let a new op start.
  assign w_fire          = bus.issue_valid & bus.issue_ready & ~squash & ~reset;
  assign bus.issue_ready = (r_count < CNT_W'(DEPTH));
  assign bus.mult_start  = w_fire;
  assign w_pop           = bus.cdb_grant & bus.cdb_valid;

  // Credit counter; fire and grant together cancel out.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_count <= '0;
    end else begin
      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Valid bits of the metadata pipe; the last stage lines up with the
  // multiplier's done for the same op. Clearing them orphans any op still
  // inside the multiplier, so its later done is ignored.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_pipeValid <= '0;
    end else begin
      r_pipeValid[0] <= w_fire;
      for (int i = 1; i < LAT; i++) r_pipeValid[i] <= r_pipeValid[i-1];
    end
  end

  // Tags only matter where the matching valid is set, so they shift freely.
  always_ff @(posedge clock) begin
    r_pipeTag[0] <= bus.issue_tag;
    for (int i = 1; i < LAT; i++) r_pipeTag[i] <= r_pipeTag[i-1];
  end

  assign w_pushData.tag   = r_pipeTag[LAT-1];
  assign w_pushData.value = bus.mult_product;

  mult_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_flush    (squash),
    .i_push     (r_pipeValid[LAT-1]),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_headData (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Head fields are forced to zero while empty so idle outputs stay clean.
  assign bus.cdb_valid = ~w_empty;
  assign bus.cdb_tag   = w_empty ? '0 : w_head.tag;
  assign bus.cdb_value = w_empty ? '0 : w_head.value;

  // A tracked op reaching the end of the pipe must coincide with done.
  assert property (@(posedge clock) disable iff (reset || squash)
                   r_pipeValid[LAT-1] |-> bus.mult_done);

  // Credits imply the buffer can never be full while an op is in flight.
  assert property (@(posedge clock) disable iff (reset || squash)
                   !(w_full && |r_pipeValid));

endmodule

// File: tb/tb_mult_result_queue.sv
// Randomised scoreboard bench for mult_result_queue. A small behavioural
// multiplier answers start pulses; an in-order reference queue predicts
// credits, start pulses and broadcasts.
module tb_mult_result_queue;
  import mult_result_queue_pkg::*;

  localparam int TAG_W = MRQ_TAG_W;
  localparam int DEPTH = 4;
  localparam int LAT   = MULT_STAGES;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic squash = 1'b0;

  always #5 clock = ~clock;

  mult_result_queue_if #(.TAG_W(TAG_W), .W(XLEN)) bus ();

  mult_result_queue #(.TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  // Behavioural multiplier: done arrives LAT cycles after start with the
  // cropped product of the operands present at start. It is never flushed.
  logic [XLEN-1:0] opA = '0;
  logic [XLEN-1:0] opB = '0;
  logic [LAT-1:0]  mulV = '0;
  logic [XLEN-1:0] mulP [LAT];

  always @(posedge clock) begin
    mulV    <= {mulV[LAT-2:0], bus.mult_start};
    mulP[0] <= opA * opB;
    for (int i = 1; i < LAT; i++) mulP[i] <= mulP[i-1];
  end

  assign bus.mult_done    = mulV[LAT-1];
  assign bus.mult_product = mulP[LAT-1];

  // Reference model: every accepted op, oldest first, with the cycle in
  // which it should first be visible on the CDB.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    int               readyCyc;
  } exp_t;

  exp_t expQ [$];
  int   cyc        = 0;
  bit   monitorOn  = 1'b0;
  bit   expReady   = 1'b1;
  bit   expStart   = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  // One cycle of stimulus, driven just after the clock edge.
  task automatic applyStimulus(input bit v, input int tag, input bit g,
                               input bit sq, input bit rst);
    logic [XLEN-1:0] prod;
    @(posedge clock);
    #1;
    cyc++;
    bus.issue_valid = v;
    bus.issue_tag   = TAG_W'(tag);
    bus.cdb_grant   = g;
    squash          = sq;
    reset           = rst;
    opA             = $urandom;
    opB             = $urandom;
    prod            = opA * opB;
    expReady        = (expQ.size() < DEPTH);
    expStart        = v && !sq && !rst && expReady;
    if (expStart)
      expQ.push_back('{tag: TAG_W'(tag), value: prod, readyCyc: cyc + LAT + 1});
    monitorOn = 1'b1;
  endtask

  task automatic idle(input int n, input bit g);
    repeat (n) applyStimulus(1'b0, 0, g, 1'b0, 1'b0);
  endtask

  // Monitor: compares every cycle on the falling edge, pops the scoreboard
  // when a broadcast is granted, and forgets everything on squash or reset.
  always @(negedge clock) begin : monBlk
    bit expV;
    if (monitorOn) begin
      expV = (expQ.size() > 0) && (expQ[0].readyCyc <= cyc);
      checkOutput("issue_ready", 64'(bus.issue_ready), 64'(expReady));
      checkOutput("mult_start", 64'(bus.mult_start), 64'(expStart));
      checkOutput("cdb_valid", 64'(bus.cdb_valid), 64'(expV));
      if (expV) begin
        checkOutput("cdb_tag", 64'(bus.cdb_tag), 64'(expQ[0].tag));
        checkOutput("cdb_value", 64'(bus.cdb_value), 64'(expQ[0].value));
        if (bus.cdb_grant && !squash && !reset) void'(expQ.pop_front());
      end else begin
        checkOutput("cdb_idle_fields", {26'(bus.cdb_tag), bus.cdb_value}, 64'(0));
      end
      if (squash || reset) expQ.delete();
    end
  end

  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_tag   = '0;
    bus.cdb_grant   = 1'b0;

    // Reset
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Single op with grant held high
    applyStimulus(1'b1, 5, 1'b1, 1'b0, 1'b0);
    idle(LAT + 3, 1'b1);

    // Back-to-back fill, refused extras, then drain
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, i, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0, 1'b0, 1'b0);
    idle(LAT, 1'b0);
    idle(6, 1'b1);

    // Full buffer with grant and issue together; pointers wrap
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 20 + i, 1'b0, 1'b0, 1'b0);
    idle(LAT + 1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 30 + i, 1'b1, 1'b0, 1'b0);
    idle(LAT + 6, 1'b1);

    // Squash two ops in flight
    applyStimulus(1'b1, 7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(LAT + 3, 1'b1);

    // Squash concurrent with issue and grant, then a normal op
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    idle(LAT + 2, 1'b0);
    applyStimulus(1'b1, 11, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 12, 1'b1, 1'b0, 1'b0);
    idle(LAT + 3, 1'b1);

    // Reset with one buffered and two in flight, then one fresh op
    applyStimulus(1'b1, 13, 1'b0, 1'b0, 1'b0);
    idle(LAT, 1'b0);
    applyStimulus(1'b1, 14, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 15, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idle(LAT + 3, 1'b1);

    // Random traffic with occasional squash and reset
    repeat (400)
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 99) == 0);
    idle(LAT + DEPTH + 4, 1'b1);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
